// File: rtl/counter_pkg.sv
// Shared constants for the parametrised up/down counter.
//   MODE_*  : encodings of the 2-bit mode input
//   DIR_*   : encodings of the step direction (dir_out and internal ping-pong dir)
package counter_pkg;
    localparam logic [1:0] MODE_UP       = 2'b00;
    localparam logic [1:0] MODE_DOWN     = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    localparam logic [1:0] MODE_HOLD     = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/clk_en_prescaler.sv
// Enable-gated prescaler: produces one tick per PRESCALE enabled cycles.
//   clk     : rising-edge clock
//   rst     : asynchronous active-low reset (prescaler phase -> 0)
//   en      : count enable; the phase freezes while low
//   restart : synchronous return of the phase to 0 (suppresses tick)
//   tick    : combinational, high on the enabled cycle that completes a period
module clk_en_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);
    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] phase_q;
    logic [15:0] phase_d;

    // With PRESCALE=1 LAST is 0, the phase never leaves 0 and tick follows en.
    assign tick = en && !restart && (phase_q == LAST);

    always_comb begin
        phase_d = phase_q;
        if (restart) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = tick ? 16'd0 : phase_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end
endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down/ping-pong counter with wrap or saturate, synchronous
// clear/load, enable-gated prescaler and a registered terminal-count pulse.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   en       : count enable (gates prescaler and stepping)
//   mode     : 00 up, 01 down, 10 ping-pong, 11 hold
//   clear    : sync, count <= RESET_VAL (wins over load)
//   load     : sync, count <= load_val clamped to MAX_VAL
//   load_val : value used by load
//   count    : registered count
//   tc       : registered one-cycle pulse when a step lands on a bound
//   dir_out  : current step direction, 0 up / 1 down
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SATURATE  = 1'b0,
    parameter int               PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             dir_out
);
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             dir_q, dir_d;          // internal ping-pong direction
    logic             dir_out_q, dir_out_d;
    logic             tick;
    logic [WIDTH-1:0] inc, dec;
    logic             eff_dir;
    logic             count_oor;             // count above MAX_VAL
    logic             load_oor;              // load_val above MAX_VAL

    clk_en_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .restart (clear | load),
        .tick    (tick)
    );

    // When MAX_VAL is the full range nothing can exceed it; splitting the
    // case avoids a comparison that is constant by construction.
    generate
        if (MAX_VAL == {WIDTH{1'b1}}) begin : g_full_range
            assign count_oor = 1'b0;
            assign load_oor  = 1'b0;
        end else begin : g_sub_range
            assign count_oor = (count_q > MAX_VAL);
            assign load_oor  = (load_val > MAX_VAL);
        end
    endgenerate

    // Modulo-2**WIDTH neighbours of the current count.
    assign inc = count_q + 1'b1;
    assign dec = count_q - 1'b1;

    // At a bound the ping-pong direction is forced to move away from it; this
    // also covers entering ping-pong with a stale stored direction.
    always_comb begin
        eff_dir = dir_q;
        if (count_oor || (count_q == MAX_VAL)) begin
            eff_dir = DIR_DOWN;
        end else if (count_q == '0) begin
            eff_dir = DIR_UP;
        end
    end

    always_comb begin
        count_d   = count_q;
        tc_d      = 1'b0;
        dir_d     = dir_q;
        dir_out_d = dir_out_q;

        if (clear) begin
            count_d = RESET_VAL;
        end else if (load) begin
            count_d = load_oor ? MAX_VAL : load_val;
        end else begin
            if (mode == MODE_PINGPONG) begin
                dir_d = eff_dir;
            end
            if (tick && (mode != MODE_HOLD)) begin
                if (count_oor) begin
                    count_d = '0;
                    dir_d   = (mode == MODE_PINGPONG) ? DIR_UP : dir_q;
                end else begin
                    case (mode)
                        MODE_UP: begin
                            if (count_q == MAX_VAL) begin
                                if (!SATURATE) count_d = '0;   // wrap is not an arrival
                            end else begin
                                count_d = inc;
                                tc_d    = (inc == MAX_VAL);
                            end
                        end
                        MODE_DOWN: begin
                            if (count_q == '0) begin
                                if (!SATURATE) count_d = MAX_VAL;
                            end else begin
                                count_d = dec;
                                tc_d    = (dec == '0);
                            end
                        end
                        MODE_PINGPONG: begin
                            // A single-value range has nowhere to move.
                            if (MAX_VAL != '0) begin
                                if (eff_dir == DIR_UP) begin
                                    count_d = inc;
                                    tc_d    = (inc == MAX_VAL);
                                    dir_d   = (inc == MAX_VAL) ? DIR_DOWN : DIR_UP;
                                end else begin
                                    count_d = dec;
                                    tc_d    = (dec == '0);
                                    dir_d   = (dec == '0) ? DIR_UP : DIR_DOWN;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end

        case (mode)
            MODE_UP:       dir_out_d = DIR_UP;
            MODE_DOWN:     dir_out_d = DIR_DOWN;
            MODE_PINGPONG: dir_out_d = dir_d;
            default:       dir_out_d = dir_out_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= RESET_VAL;
            tc_q      <= 1'b0;
            dir_q     <= DIR_UP;
            dir_out_q <= DIR_UP;
        end else begin
            count_q   <= count_d;
            tc_q      <= tc_d;
            dir_q     <= dir_d;
            dir_out_q <= dir_out_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign dir_out = dir_out_q;
endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: five instances with different
// parameter sets share clock and inputs; each phase resets all of them and
// checks the instance it targets.
module tb_updown_counter_param;
    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       clear;
    logic       load;
    logic [8:0] lv;

    logic [7:0] a_cnt; logic a_tc; logic a_dir;   // WIDTH 8, full range, wrap
    logic [3:0] b_cnt; logic b_tc; logic b_dir;   // WIDTH 4, MAX 9
    logic [1:0] c_cnt; logic c_tc; logic c_dir;   // WIDTH 2, MAX 3
    logic [8:0] d_cnt; logic d_tc; logic d_dir;   // WIDTH 9, MAX 255, saturate
    logic [7:0] e_cnt; logic e_tc; logic e_dir;   // PRESCALE 4, RESET_VAL 5

    int n_checks = 0;
    int n_err    = 0;

    updown_counter_param u_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clear(clear), .load(load),
        .load_val(lv[7:0]), .count(a_cnt), .tc(a_tc), .dir_out(a_dir)
    );
    updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd9)) u_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clear(clear), .load(load),
        .load_val(lv[3:0]), .count(b_cnt), .tc(b_tc), .dir_out(b_dir)
    );
    updown_counter_param #(.WIDTH(2), .MAX_VAL(2'd3)) u_c (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clear(clear), .load(load),
        .load_val(lv[1:0]), .count(c_cnt), .tc(c_tc), .dir_out(c_dir)
    );
    updown_counter_param #(.WIDTH(9), .MAX_VAL(9'd255), .SATURATE(1'b1)) u_d (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clear(clear), .load(load),
        .load_val(lv), .count(d_cnt), .tc(d_tc), .dir_out(d_dir)
    );
    updown_counter_param #(.WIDTH(8), .RESET_VAL(8'd5), .PRESCALE(4)) u_e (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clear(clear), .load(load),
        .load_val(lv[7:0]), .count(e_cnt), .tc(e_tc), .dir_out(e_dir)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle away from it.
    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; en = 1'b0; clear = 1'b0; load = 1'b0; lv = '0;
        edge1();
        rst = 1'b1;
    endtask

    int exp_c_cnt[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    int exp_c_tc [8] = '{0, 0, 1, 0, 0, 1, 0, 0};
    int exp_c_dir[8] = '{0, 0, 1, 1, 1, 0, 0, 0};
    int ens      [6] = '{1, 1, 0, 0, 1, 1};
    int exp_e    [6] = '{5, 5, 5, 5, 5, 6};

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; clear = 1'b0; load = 1'b0; lv = '0;
        #1;
        // reset values
        rst = 1'b0;
        #1;
        chk("reset_a_cnt", 32'(a_cnt), 0);
        chk("reset_a_tc",  32'(a_tc),  0);
        chk("reset_a_dir", 32'(a_dir), 0);
        chk("reset_e_cnt", 32'(e_cnt), 5);
        edge1();
        rst = 1'b1;

        // down count with wrap, tc only on arrival at 0
        mode = 2'b01; en = 1'b1;
        edge1();
        chk("down_wrap_cnt", 32'(a_cnt), 255);
        chk("down_wrap_tc",  32'(a_tc),  0);
        chk("down_dir",      32'(a_dir), 1);
        edge1();
        chk("down_254", 32'(a_cnt), 254);
        for (int i = 0; i < 253; i++) begin
            edge1();
            chk("down_run_cnt", 32'(a_cnt), 32'(253 - i));
            chk("down_run_tc",  32'(a_tc),  0);
        end
        edge1();
        chk("down_zero_cnt", 32'(a_cnt), 0);
        chk("down_zero_tc",  32'(a_tc),  1);
        edge1();
        chk("down_after_cnt", 32'(a_cnt), 255);
        chk("down_after_tc",  32'(a_tc),  0);
        // hold mode keeps count and last direction
        mode = 2'b11;
        edge1();
        chk("hold_cnt", 32'(a_cnt), 255);
        chk("hold_dir", 32'(a_dir), 1);
        chk("hold_tc",  32'(a_tc),  0);

        // up count modulo 10
        do_reset();
        mode = 2'b00; en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            edge1();
            chk("mod10_cnt", 32'(b_cnt), 32'(k));
            chk("mod10_tc",  32'(b_tc),  (k == 9) ? 1 : 0);
        end
        edge1();
        chk("mod10_wrap_cnt", 32'(b_cnt), 0);
        chk("mod10_wrap_tc",  32'(b_tc),  0);
        chk("mod10_dir",      32'(b_dir), 0);

        // ping-pong over 0..3
        do_reset();
        mode = 2'b10; en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            edge1();
            chk("pp_cnt", 32'(c_cnt), 32'(exp_c_cnt[k]));
            chk("pp_tc",  32'(c_tc),  32'(exp_c_tc[k]));
            chk("pp_dir", 32'(c_dir), 32'(exp_c_dir[k]));
        end

        // saturating up count after load, then clamped load
        do_reset();
        mode = 2'b00; en = 1'b1; lv = 9'd250; load = 1'b1;
        edge1();
        load = 1'b0;
        chk("sat_load_cnt", 32'(d_cnt), 250);
        chk("sat_load_tc",  32'(d_tc),  0);
        for (int k = 251; k <= 255; k++) begin
            edge1();
            chk("sat_cnt", 32'(d_cnt), 32'(k));
            chk("sat_tc",  32'(d_tc),  (k == 255) ? 1 : 0);
        end
        repeat (2) begin
            edge1();
            chk("sat_hold_cnt", 32'(d_cnt), 255);
            chk("sat_hold_tc",  32'(d_tc),  0);
        end
        lv = 9'd300; load = 1'b1;
        edge1();
        load = 1'b0;
        chk("load_clamp_cnt", 32'(d_cnt), 255);
        chk("load_trunc_a",   32'(a_cnt), 44);

        // prescaler gated by en, then clear+load together
        do_reset();
        mode = 2'b00;
        for (int k = 0; k < 6; k++) begin
            en = ens[k][0];
            edge1();
            chk("presc_cnt", 32'(e_cnt), 32'(exp_e[k]));
        end
        en = 1'b1; clear = 1'b1; load = 1'b1; lv = 9'd100;
        edge1();
        clear = 1'b0; load = 1'b0;
        chk("clr_ld_cnt", 32'(e_cnt), 5);
        chk("clr_ld_tc",  32'(e_tc),  0);
        for (int k = 1; k <= 4; k++) begin
            edge1();
            chk("presc_restart", 32'(e_cnt), (k == 4) ? 6 : 5);
        end

        // asynchronous reset mid-count
        do_reset();
        mode = 2'b00; en = 1'b1;
        repeat (37) edge1();
        chk("mid_cnt_37", 32'(a_cnt), 37);
        rst = 1'b0;
        #2;
        chk("async_rst_cnt", 32'(a_cnt), 0);
        chk("async_rst_tc",  32'(a_tc),  0);
        chk("async_rst_e",   32'(e_cnt), 5);
        rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            edge1();
            chk("resume_a", 32'(a_cnt), 32'(k));
            chk("resume_e", 32'(e_cnt), (k == 4) ? 6 : 5);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
